// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared state encoding, default sizes and counter-width helper for the SAR ADC controller
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH         = 10;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 2;

    // Bits needed to hold the larger of the two phase lengths as a down-count value.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sar_approx_reg.sv
// rtl/sar_approx_reg.sv - successive-approximation trial register and bit index
module sar_approx_reg
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             step,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] trial,
    output logic             last_bit
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE = IW'(1);
    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] bit_mask;

    assign bit_mask = LSB_ONE << bit_idx;
    assign last_bit = (bit_idx == '0);

    // Resolve the current bit from the comparator and arm the next lower one;
    // the shifted mask is empty on bit 0, so nothing further is armed there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trial   <= '0;
            bit_idx <= '0;
        end else if (init) begin
            trial   <= MSB_ONE;
            bit_idx <= IDX_TOP;
        end else if (step) begin
            trial <= (trial & ~bit_mask) | (cmp_in ? bit_mask : '0) | (bit_mask >> 1);
            if (!last_bit) begin
                bit_idx <= bit_idx - IDX_ONE;
            end
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - SAR ADC conversion sequencer; optional ADC_AUTO_TRIGGER_EN adds a periodic internal trigger
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
`ifdef ADC_AUTO_TRIGGER_EN
    ,
    parameter int TRIG_PERIOD   = 40
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_in,
    input  logic             clr_overrun,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    localparam int CW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             init, step, trig, last_bit;
    logic [WIDTH-1:0] trial;

`ifdef ADC_AUTO_TRIGGER_EN
    localparam int TW = (TRIG_PERIOD > 1) ? $clog2(TRIG_PERIOD) : 1;
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_PERIOD - 1);

    logic [TW-1:0] trig_cnt;
    logic          auto_trig;

    assign auto_trig = (trig_cnt == TRIG_LAST);
    assign trig      = start | auto_trig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_cnt <= '0;
        end else if (auto_trig) begin
            trig_cnt <= '0;
        end else begin
            trig_cnt <= trig_cnt + TW'(1);
        end
    end
`else
    assign trig = start;
`endif

    sar_approx_reg #(
        .WIDTH (WIDTH)
    ) u_approx (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .step     (step),
        .cmp_in   (cmp_in),
        .trial    (trial),
        .last_bit (last_bit)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = CONVERT;
                    cnt_nxt   = SETTLE_LOAD;
                    init      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            CONVERT: begin
                // cmp_in is taken on the final settle cycle of each bit.
                if (cnt == CNT_ONE) begin
                    step = 1'b1;
                    if (last_bit) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = SETTLE_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            result_valid <= (state == DONE);
            if (state == DONE) begin
                result <= trial;
            end
            if (trig && busy) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign sample_en = (state == SAMPLE);
    assign dac_code  = ((state == CONVERT) || (state == DONE)) ? trial : '0;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl with an ideal comparator model
module tb_sar_adc_ctrl;

    localparam int W   = 10;
    localparam int S   = 4;
    localparam int T   = 2;
    localparam int LAT = S + W * T + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [W-1:0]  vin = '0;
    logic          cmp_in;
    logic          sample_en;
    logic [W-1:0]  dac_code;
    logic          busy;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          overrun;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] trials [W];

    // Conversion progress measured in cycles since the accepting edge; 0 means idle.
    int           m_t = 0;
    logic [W-1:0] m_vin = '0;
    logic [W-1:0] m_res = '0;
    logic         m_rv = 1'b0;
    logic         m_ov = 1'b0;

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_code);

    sar_adc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmp_in       (cmp_in),
        .clr_overrun  (clr_overrun),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ideal SAR: at bit k the code holds vin's bits above k and a trial 1 at k.
    function automatic logic [W-1:0] exp_dac(input int t, input logic [W-1:0] v);
        int k;
        int vi;
        vi = int'(v);
        if (t >= S + 1 && t <= S + W * T) begin
            k  = W - 1 - (t - S - 1) / T;
            vi = ((vi >> (k + 1)) << (k + 1)) | (1 << k);
            return W'(vi);
        end else if (t == LAT) begin
            return v;
        end
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t   <= 0;
            m_vin <= '0;
            m_res <= '0;
            m_rv  <= 1'b0;
            m_ov  <= 1'b0;
        end else begin
            m_rv <= (m_t == LAT);
            if (m_t == LAT) m_res <= m_vin;
            if (start && m_t != 0) m_ov <= 1'b1;
            else if (clr_overrun) m_ov <= 1'b0;
            if (m_t == 0) begin
                if (start) begin
                    m_t   <= 1;
                    m_vin <= vin;
                end
            end else if (m_t == LAT) begin
                m_t <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_sample_en", 32'(sample_en), 32'(m_t >= 1 && m_t <= S));
            chk("cyc_busy", 32'(busy), 32'(m_t != 0));
            chk("cyc_dac_code", 32'(dac_code), 32'(exp_dac(m_t, m_vin)));
            chk("cyc_result", 32'(result), 32'(m_res));
            chk("cyc_result_valid", 32'(result_valid), 32'(m_rv));
            chk("cyc_overrun", 32'(overrun), 32'(m_ov));
        end
    end

    task automatic run_conv(input logic [W-1:0] v, input int inj, input logic inj_clr,
                            output int lat, output int sen);
        int n;
        lat = -1;
        sen = 0;
        n   = 0;
        vin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (sample_en) sen++;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (sample_en) sen++;
            if (n >= S && n < S + W * T && ((n - S) % T) == 0) trials[(n - S) / T] = dac_code;
            if (result_valid) begin
                lat = n;
                break;
            end
            start       = (n == inj);
            clr_overrun = (n == inj) && inj_clr;
        end
        start       = 1'b0;
        clr_overrun = 1'b0;
        if (lat < 0) chk("conv_timeout", 32'(lat), 32'(LAT));
    endtask

    initial begin
        int lat;
        int sen;
        int n;
        int p1;
        int p2;
        logic [W-1:0] msb;
        msb = 10'h200;

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_dac_code", 32'(dac_code), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));

        run_conv(10'h200, -1, 1'b0, lat, sen);
        chk("mid_result", 32'(result), 32'h200);
        chk("mid_latency", 32'(lat), 32'd25);
        chk("mid_sample_cycles", 32'(sen), 32'd4);

        run_conv(10'h000, -1, 1'b0, lat, sen);
        chk("zero_result", 32'(result), 32'h000);
        for (int i = 0; i < W; i++) chk("zero_trial", 32'(trials[i]), 32'(msb >> i));

        run_conv(10'h3FF, -1, 1'b0, lat, sen);
        chk("full_result", 32'(result), 32'h3FF);
        run_conv(10'h155, -1, 1'b0, lat, sen);
        chk("alt_result", 32'(result), 32'h155);
        chk("no_overrun_yet", 32'(overrun), 32'(0));

        run_conv(10'h2C3, 8, 1'b0, lat, sen);
        chk("ovr_result", 32'(result), 32'h2C3);
        chk("ovr_latency", 32'(lat), 32'd25);
        chk("ovr_set", 32'(overrun), 32'(1));

        @(posedge clk);
        #2 clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_cleared", 32'(overrun), 32'(0));
        clr_overrun = 1'b0;

        run_conv(10'h0F0, 10, 1'b1, lat, sen);
        chk("ovr_set_wins", 32'(overrun), 32'(1));
        chk("ovr_set_wins_result", 32'(result), 32'h0F0);

        @(posedge clk);
        #2;
        vin   = 10'h3C0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_sample_en", 32'(sample_en), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_dac_code", 32'(dac_code), 32'(0));
        chk("mid_rst_result", 32'(result), 32'(0));
        chk("mid_rst_result_valid", 32'(result_valid), 32'(0));
        chk("mid_rst_overrun", 32'(overrun), 32'(0));
        @(posedge clk);
        #2 reset = 1'b0;
        run_conv(10'h0AA, -1, 1'b0, lat, sen);
        chk("post_rst_result", 32'(result), 32'h0AA);

        @(posedge clk);
        #2;
        vin   = 10'h1E7;
        start = 1'b1;
        n  = 0;
        p1 = -1;
        p2 = -1;
        @(posedge clk);
        while (n < 100 && p2 < 0) begin
            @(posedge clk);
            n++;
            #1;
            if (result_valid) begin
                if (p1 < 0) p1 = n;
                else p2 = n;
            end
        end
        start = 1'b0;
        chk("b2b_first", 32'(p1), 32'd25);
        chk("b2b_period", 32'(p2 - p1), 32'd26);
        chk("b2b_result", 32'(result), 32'h1E7);
        repeat (30) @(posedge clk);
        #2;
        chk("b2b_idle", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
